// File: rtl/vs_fifo.sv
// Valid/stall FIFO with first-word fall-through output, occupancy count and a
// skid slot: stall_us rises one entry early so a late upstream beat still fits.
module vs_fifo #(
  parameter int WIDTH = 8,
  parameter int K     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_us,
  input  logic [WIDTH-1:0] data_us,
  output logic             stall_us,
  output logic             valid_ds,
  output logic [WIDTH-1:0] data_ds,
  input  logic             stall_ds,
  output logic [K:0]       count,
  output logic             overflow
);

  localparam int         DEPTH       = 1 << K;
  localparam logic [K:0] C_ONE       = (K+1)'(1);
  localparam logic [K:0] C_STALL_LVL = (K+1)'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [K:0]       r_wptr;
  logic [K:0]       r_rptr;
  logic [K:0]       r_count;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Handshake: a downstream beat transfers on any edge where valid_ds=1 and
  // stall_ds=0. An upstream beat is taken whenever valid_us=1 and there is room
  // (including room freed by a same-cycle pop); stall_us is advisory only, and
  // a beat offered into a full FIFO with no pop is dropped and flagged.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[K] != r_rptr[K]) && (r_wptr[K-1:0] == r_rptr[K-1:0]);
  assign w_pop   = ~w_empty & ~stall_ds;
  assign w_push  = valid_us & (~w_full | w_pop);
  assign w_drop  = valid_us & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + C_ONE;
      if (w_pop)  r_rptr <= r_rptr + C_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Storage is never cleared; only the head under valid_ds is meaningful.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[K-1:0]] <= data_us;
  end

  assign valid_ds = ~w_empty;
  assign data_ds  = r_mem[r_rptr[K-1:0]];
  assign count    = r_count;
  assign stall_us = (r_count >= C_STALL_LVL);
  assign overflow = r_overflow;

endmodule

// File: tb/tb_vs_fifo.sv
// Directed bench for vs_fifo (K=2, WIDTH=8): a queue model of the FIFO rules is
// compared against the DUT every cycle, with literal checks pinning the model.
module tb_vs_fifo;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic       valid_us;
  logic [7:0] data_us;
  logic       stall_us;
  logic       valid_ds;
  logic [7:0] data_ds;
  logic       stall_ds;
  logic [2:0] count;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] out_log[$];
  logic       m_ovf;

  vs_fifo #(.WIDTH(8), .K(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_us (valid_us),
    .data_us  (data_us),
    .stall_us (stall_us),
    .valid_ds (valid_ds),
    .data_ds  (data_ds),
    .stall_ds (stall_ds),
    .count    (count),
    .overflow (overflow)
  );

  // clock / reset
  initial begin
    clk    = 1'b0;
    clk_en = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of at most four beats.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      automatic bit m_pop  = (exp_q.size() != 0) && !stall_ds;
      automatic bit m_full = (exp_q.size() == 4);
      automatic bit m_push = valid_us && (!m_full || m_pop);
      if (valid_us && !m_push) m_ovf = 1'b1;
      if (m_pop) out_log.push_back(exp_q.pop_front());
      if (m_push) exp_q.push_back(data_us);
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid_ds", 32'(valid_ds), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("data_ds", 32'(data_ds), 32'(exp_q[0]));
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("stall_us", 32'(stall_us), 32'(exp_q.size() >= 3));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  // driver: apply inputs for one cycle, return just after the following negedge
  task automatic cyc(input logic v, input logic [7:0] d, input logic s);
    valid_us = v;
    data_us  = d;
    stall_ds = s;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(valid_ds), 32'd0);
    chk("rst_stall", 32'(stall_us), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    #1;
    rst = 1'b0;
    out_log.delete();
  endtask

  initial begin
    logic [7:0] exp_drain [4];
    logic [7:0] exp_pass [5];
    int         next;
    int         max_cnt;
    logic       stall_seen;
    rst      = 1'b0;
    valid_us = 1'b0;
    data_us  = '0;
    stall_ds = 1'b0;

    // reset with no clock running
    #3 rst = 1'b1;
    #1;
    chk("por_valid", 32'(valid_ds), 32'd0);
    chk("por_stall", 32'(stall_us), 32'd0);
    chk("por_count", 32'(count), 32'd0);
    chk("por_ovf", 32'(overflow), 32'd0);
    #2 rst = 1'b0;
    clk_en = 1'b1;

    // one-cycle latency
    cyc(1'b1, 8'hA1, 1'b0);
    chk("lat_valid", 32'(valid_ds), 32'd1);
    chk("lat_data", 32'(data_ds), 32'hA1);
    chk("lat_count", 32'(count), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("lat_empty", 32'(valid_ds), 32'd0);
    chk("lat_count0", 32'(count), 32'd0);

    // fill, skid slot, overflow, drain
    out_log.delete();
    cyc(1'b1, 8'h01, 1'b1);
    cyc(1'b1, 8'h02, 1'b1);
    cyc(1'b1, 8'h03, 1'b1);
    chk("fill_count3", 32'(count), 32'd3);
    chk("fill_stall", 32'(stall_us), 32'd1);
    cyc(1'b1, 8'h04, 1'b1);
    chk("skid_count4", 32'(count), 32'd4);
    chk("skid_ovf0", 32'(overflow), 32'd0);
    cyc(1'b1, 8'h05, 1'b1);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count4", 32'(count), 32'd4);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    exp_drain = '{8'h01, 8'h02, 8'h03, 8'h04};
    chk("drain_len", 32'(out_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < out_log.size()) chk("drain_data", 32'(out_log[i]), 32'(exp_drain[i]));

    // clear the sticky flag, then full pass-through
    mid_reset();
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b1);
    chk("pt_full", 32'(count), 32'd4);
    chk("pt_head", 32'(data_ds), 32'h01);
    cyc(1'b1, 8'h10, 1'b0);
    chk("pt_count", 32'(count), 32'd4);
    chk("pt_head2", 32'(data_ds), 32'h02);
    chk("pt_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b0);
    exp_pass = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h10};
    chk("pt_len", 32'(out_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < out_log.size()) chk("pt_data", 32'(out_log[i]), 32'(exp_pass[i]));

    // wrap: upstream reacts to stall_us one cycle late, random downstream stall
    out_log.delete();
    next       = 0;
    max_cnt    = 0;
    stall_seen = 1'b0;
    for (int c = 0; c < 400 && out_log.size() < 16; c++) begin
      automatic logic v = (next < 16) && !stall_seen;
      automatic logic s = 1'($urandom_range(0, 1));
      stall_seen = stall_us;
      cyc(v, 8'(next), s);
      if (v) next++;
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    chk("wrap_len", 32'(out_log.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < out_log.size()) chk("wrap_data", 32'(out_log[i]), 32'(i));
    chk("wrap_maxcnt_le4", 32'(max_cnt <= 4), 32'd1);
    chk("wrap_ovf", 32'(overflow), 32'd0);

    // reset mid-operation
    cyc(1'b1, 8'h31, 1'b1);
    cyc(1'b1, 8'h32, 1'b1);
    cyc(1'b1, 8'h33, 1'b1);
    chk("mr_count3", 32'(count), 32'd3);
    valid_us = 1'b0;
    mid_reset();
    cyc(1'b1, 8'h5A, 1'b0);
    chk("mr_valid", 32'(valid_ds), 32'd1);
    chk("mr_data", 32'(data_ds), 32'h5A);
    cyc(1'b0, 8'h00, 1'b0);
    chk("mr_out", 32'((out_log.size() == 1) ? out_log[0] : 8'hFF), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vs_fifo.md
VS_FIFO -- requirements
Module: vs_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, payload bit width.
REQ-002 SHALL have parameter K, default 2, log2 of depth; DEPTH = 2^K; legal K >= 1.
REQ-003 SHALL have port clk  input  1  clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port valid_us  input  1  upstream beat present.
REQ-006 SHALL have port data_us  input  WIDTH  upstream payload.
REQ-007 SHALL have port stall_us  output  1  stall request to upstream.
REQ-008 SHALL have port valid_ds  output  1  downstream beat present.
REQ-009 SHALL have port data_ds  output  WIDTH  downstream payload, head of queue.
REQ-010 SHALL have port stall_ds  input  1  downstream stall, meaningful only while valid_ds=1.
REQ-011 SHALL have port count  output  K+1  current occupancy, 0..DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky error, upstream beat dropped.

Function
REQ-013 SHALL store up to DEPTH entries in FIFO order; K+1-bit read/write pointers wrap modulo 2^(K+1); empty = pointers equal, full = MSBs differ and low K bits equal.
REQ-014 SHALL define pop = valid_ds & ~stall_ds; pop advances read pointer at the next clk edge.
REQ-015 SHALL define push = valid_us & (~full | pop); push writes data_us at write pointer and advances the write pointer at the next clk edge.
REQ-016 SHALL drive valid_ds = ~empty and data_ds = entry at read pointer (first-word fall-through); no combinational path from valid_us/data_us to valid_ds/data_ds.
REQ-017 SHALL give 1-cycle latency: a beat pushed at edge N into an empty FIFO appears on data_ds with valid_ds=1 after edge N.
REQ-018 SHALL update count each edge: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-019 SHALL drive stall_us = (count >= DEPTH-1), decoded from registered state only; the last free slot is a skid slot absorbing the one beat upstream may issue in the cycle it first sees stall_us.
REQ-020 SHALL accept valid_us whenever push holds, regardless of stall_us.
REQ-021 SHALL, on valid_us=1 while full and pop=0, drop data_us, leave pointers and count unchanged, and set overflow=1 at the next edge.
REQ-022 SHALL hold overflow at 1 until reset; nothing but rst clears it.
REQ-023 SHALL, on simultaneous push and pop when full, accept the new beat and emit the head; count stays DEPTH; overflow unaffected.
REQ-024 SHALL, on simultaneous push and pop when count=1, emit the old head this cycle and present the new beat the next cycle with valid_ds=1.
REQ-025 SHALL ignore stall_ds while valid_ds=0.
REQ-026 SHALL NOT require storage contents to be cleared on pop; only data_ds while valid_ds=1 is meaningful.

Reset
REQ-027 SHALL, while rst=1, asynchronously force pointers=0, count=0, valid_ds=0, stall_us=0, overflow=0, independent of clk.
REQ-028 SHALL, on rst asserted mid-operation, discard all queued entries; the first push after release is the first beat out.
REQ-029 SHALL NOT require storage array reset; data_ds value is don't-care while valid_ds=0.

Verification (K=2, DEPTH=4, WIDTH=8)
REQ-030 SHALL cover reset: pulse rst with no clk -> valid_ds=0, stall_us=0, count=0, overflow=0 immediately.
REQ-031 SHALL cover latency: push 0xA1 into empty at edge 0 -> after edge 0 valid_ds=1, data_ds=0xA1, count=1; stall_ds=0 -> after edge 1 valid_ds=0, count=0.
REQ-032 SHALL cover fill and skid: stall_ds=1, push 0x01,0x02,0x03 -> count=3, stall_us=1; push 0x04 -> count=4, overflow=0; push 0x05 -> overflow=1, count=4, then drain yields 0x01..0x04 only.
REQ-033 SHALL cover full pass-through: count=4, valid_us=1 data 0x10, stall_ds=0 -> count stays 4, data_ds advances 0x01->0x02, overflow=0, 0x10 emerges fifth.
REQ-034 SHALL cover wrap: stream 0x00..0x0F with random stall_ds, upstream honoring stall_us with one-cycle reaction -> output sequence 0x00..0x0F in order, count <= 4, overflow=0.
REQ-035 SHALL cover reset mid-operation: count=3, assert rst between edges -> count=0, valid_ds=0 at once; after release push 0x5A -> data_ds=0x5A after next edge.
